sm_fir4: RTL and testbench

Four-tap FIR stage sitting directly downstream of the three-stage sample delay line in the anspwm noise-shaping path. It consumes the current sign-magnitude sample plus its 1-, 2- and 3-clock delayed copies with their signs, computes a weighted sum with one sequential multiply-accumulate over four cycles, then normalises, saturates and returns a sign-magnitude result. Its output feeds the quantiser/PWM stage.

---
 rtl/sm_fir4.sv | 173 +++++++++++++++++
 tb/tb_sm_fir4.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_fir4.sv
// Four-tap sign-magnitude FIR stage: one sequential MAC over four cycles, then normalise/saturate.
// Optional build macro SM_FIR4_ROUND_EN selects round-half-up instead of floor in normalisation.
module sm_fir4 #(
    parameter logic signed [15:0] C0 = 16'sd8192,
    parameter logic signed [15:0] C1 = 16'sd8192,
    parameter logic signed [15:0] C2 = 16'sd0,
    parameter logic signed [15:0] C3 = 16'sd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic        xs_in,
    input  logic [15:0] d1_in,
    input  logic        d1s_in,
    input  logic [15:0] d2_in,
    input  logic        d2s_in,
    input  logic [15:0] d3_in,
    input  logic        d3s_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] y_out,
    output logic        ys_out,
    output logic        ovf_out
);

    typedef enum logic [2:0] {
        StIdle,
        StMac0,
        StMac1,
        StMac2,
        StMac3,
        StNorm
    } state_e;

    state_e             state_q, state_d;
    logic signed [16:0] smp_q [4];
    logic signed [16:0] smp_d [4];
    logic signed [35:0] acc_q, acc_d;
    logic [15:0]        y_q, y_d;
    logic               ys_q, ys_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic signed [16:0] mac_x;
    logic signed [15:0] mac_c;
    logic signed [32:0] prod;
    logic signed [35:0] prod_ext;
    logic signed [36:0] acc_adj;
    logic signed [36:0] r_full;
    logic [36:0]        r_mag;
    logic               r_sat;

    // Negative zero naturally maps to 0 through the negation.
    function automatic logic signed [16:0] to_tc(input logic [15:0] mag, input logic neg);
        logic signed [16:0] v;
        v = $signed({1'b0, mag});
        return neg ? -v : v;
    endfunction

    always_comb begin
        mac_x = '0;
        mac_c = '0;
        case (state_q)
            StMac0: begin
                mac_x = smp_q[0];
                mac_c = C0;
            end
            StMac1: begin
                mac_x = smp_q[1];
                mac_c = C1;
            end
            StMac2: begin
                mac_x = smp_q[2];
                mac_c = C2;
            end
            StMac3: begin
                mac_x = smp_q[3];
                mac_c = C3;
            end
            default: begin
                mac_x = '0;
                mac_c = '0;
            end
        endcase
        prod     = mac_x * mac_c;
        prod_ext = $signed({{3{prod[32]}}, prod});
    end

    always_comb begin
`ifdef SM_FIR4_ROUND_EN
        acc_adj = $signed({acc_q[35], acc_q}) + 37'sd8192;
`else
        acc_adj = $signed({acc_q[35], acc_q});
`endif
        r_full = acc_adj >>> 14;
        r_mag  = r_full[36] ? 37'(-r_full) : 37'(r_full);
        r_sat  = r_mag > 37'd65535;
    end

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        acc_d   = acc_q;
        y_d     = y_q;
        ys_d    = ys_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    smp_d[0] = to_tc(x_in, xs_in);
                    smp_d[1] = to_tc(d1_in, d1s_in);
                    smp_d[2] = to_tc(d2_in, d2s_in);
                    smp_d[3] = to_tc(d3_in, d3s_in);
                    acc_d    = '0;
                    state_d  = StMac0;
                end
            end
            StMac0: begin
                acc_d   = acc_q + prod_ext;
                state_d = StMac1;
            end
            StMac1: begin
                acc_d   = acc_q + prod_ext;
                state_d = StMac2;
            end
            StMac2: begin
                acc_d   = acc_q + prod_ext;
                state_d = StMac3;
            end
            StMac3: begin
                acc_d   = acc_q + prod_ext;
                state_d = StNorm;
            end
            StNorm: begin
                y_d     = r_sat ? 16'hFFFF : r_mag[15:0];
                ovf_d   = r_sat;
                ys_d    = r_full[36];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            smp_q   <= '{default: '0};
            acc_q   <= '0;
            y_q     <= '0;
            ys_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            ys_q    <= ys_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign y_out   = y_q;
    assign ys_out  = ys_q;
    assign ovf_out = ovf_q;

endmodule

// File: tb/tb_sm_fir4.sv
// Bench for sm_fir4: four parameterisations share one stimulus bus and are checked
// against a signed-integer reference model plus fixed vectors and timing sequences.
module tb_sm_fir4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] x, d1, d2, d3;
    logic        xs, d1s, d2s, d3s;
    logic        busy [4];
    logic        done [4];
    logic [15:0] y    [4];
    logic        ys   [4];
    logic        ovf  [4];

    int n_vec = 0;
    int n_err = 0;

    // Coefficients of the four instances, in tap order.
    int coef [4][4] = '{'{8192, 8192, 0, 0},
                        '{32767, 32767, 32767, 32767},
                        '{8192, 0, 0, 0},
                        '{-12345, 20000, 7000, -32768}};

    sm_fir4 #(.C0(16'sd8192), .C1(16'sd8192), .C2(16'sd0), .C3(16'sd0)) u_def (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x), .xs_in(xs), .d1_in(d1), .d1s_in(d1s),
        .d2_in(d2), .d2s_in(d2s), .d3_in(d3), .d3s_in(d3s),
        .busy(busy[0]), .done(done[0]), .y_out(y[0]), .ys_out(ys[0]), .ovf_out(ovf[0])
    );
    sm_fir4 #(.C0(16'sd32767), .C1(16'sd32767), .C2(16'sd32767), .C3(16'sd32767)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x), .xs_in(xs), .d1_in(d1), .d1s_in(d1s),
        .d2_in(d2), .d2s_in(d2s), .d3_in(d3), .d3s_in(d3s),
        .busy(busy[1]), .done(done[1]), .y_out(y[1]), .ys_out(ys[1]), .ovf_out(ovf[1])
    );
    sm_fir4 #(.C0(16'sd8192), .C1(16'sd0), .C2(16'sd0), .C3(16'sd0)) u_rnd (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x), .xs_in(xs), .d1_in(d1), .d1s_in(d1s),
        .d2_in(d2), .d2s_in(d2s), .d3_in(d3), .d3s_in(d3s),
        .busy(busy[2]), .done(done[2]), .y_out(y[2]), .ys_out(ys[2]), .ovf_out(ovf[2])
    );
    sm_fir4 #(.C0(-16'sd12345), .C1(16'sd20000), .C2(16'sd7000), .C3(-16'sd32768)) u_mix (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x), .xs_in(xs), .d1_in(d1), .d1s_in(d1s),
        .d2_in(d2), .d2s_in(d2s), .d3_in(d3), .d3s_in(d3s),
        .busy(busy[3]), .done(done[3]), .y_out(y[3]), .ys_out(ys[3]), .ovf_out(ovf[3])
    );

    typedef struct {
        int          inst;
        logic [15:0] m [4];
        logic        s [4];
        int          ey;
        int          eys;
        int          eovf;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Weighted sum in plain integers, scaled by 2^-14 with floor (or round-half-up).
    function automatic void model(input int inst, input logic [15:0] m [4], input logic s [4],
                                  output int ey, output int eys, output int eovf);
        longint sum, r, mag;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            sum += (s[k] ? -longint'(m[k]) : longint'(m[k])) * longint'(coef[inst][k]);
        end
`ifdef SM_FIR4_ROUND_EN
        sum += 8192;
`endif
        if (sum >= 0) r = sum / 16384;
        else r = -((-sum + 16383) / 16384);
        mag  = (r < 0) ? -r : r;
        eovf = (mag > 65535) ? 1 : 0;
        ey   = (mag > 65535) ? 65535 : int'(mag);
        eys  = (r < 0) ? 1 : 0;
    endfunction

    task automatic drive(input logic [15:0] m [4], input logic s [4]);
        x = m[0]; d1 = m[1]; d2 = m[2]; d3 = m[3];
        xs = s[0]; d1s = s[1]; d2s = s[2]; d3s = s[3];
    endtask

    task automatic scramble();
        x = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom); d3 = 16'($urandom);
        {xs, d1s, d2s, d3s} = 4'($urandom);
    endtask

    task automatic check_all(input logic [15:0] m [4], input logic s [4]);
        int ey, eys, eovf;
        for (int i = 0; i < 4; i++) begin
            model(i, m, s, ey, eys, eovf);
            chk($sformatf("y[%0d]", i), longint'(y[i]), longint'(ey));
            chk($sformatf("ys[%0d]", i), longint'(ys[i]), longint'(eys));
            chk($sformatf("ovf[%0d]", i), longint'(ovf[i]), longint'(eovf));
        end
    endtask

    // One start pulse; inputs change after E0 to prove they are latched only there.
    task automatic run_txn(input logic [15:0] m [4], input logic s [4]);
        int lat;
        bit busy_ok;
        @(negedge clk);
        drive(m, s);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        scramble();
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (done[0]) begin
                lat = k;
                break;
            end
            if (!busy[0]) busy_ok = 1'b0;
        end
        chk("latency", longint'(lat), 64'd5);
        chk("busy_window", longint'(busy_ok), 64'd1);
        chk("busy_at_done", longint'(busy[0]), 64'd0);
        check_all(m, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        logic [15:0] m [4];
        logic        s [4];
        int ndone, first, second;

        tbl[0] = '{0, '{16'd1000, 16'd3000, 16'd0, 16'd0}, '{0, 0, 0, 0}, 2000, 0, 0};
        tbl[1] = '{0, '{16'd100, 16'd100, 16'd0, 16'd0}, '{1, 0, 0, 0}, 0, 0, 0};
        tbl[2] = '{0, '{16'd0, 16'd0, 16'd0, 16'd0}, '{1, 0, 0, 0}, 0, 0, 0};
        tbl[3] = '{1, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{0, 0, 0, 0}, 65535, 0, 1};
        tbl[4] = '{1, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{1, 1, 1, 1}, 65535, 1, 1};
`ifdef SM_FIR4_ROUND_EN
        tbl[5] = '{2, '{16'd3, 16'd0, 16'd0, 16'd0}, '{0, 0, 0, 0}, 2, 0, 0};
        tbl[6] = '{2, '{16'd3, 16'd0, 16'd0, 16'd0}, '{1, 0, 0, 0}, 1, 1, 0};
        tbl[7] = '{0, '{16'd1, 16'd0, 16'd0, 16'd0}, '{1, 0, 0, 0}, 0, 0, 0};
`else
        tbl[5] = '{2, '{16'd3, 16'd0, 16'd0, 16'd0}, '{0, 0, 0, 0}, 1, 0, 0};
        tbl[6] = '{2, '{16'd3, 16'd0, 16'd0, 16'd0}, '{1, 0, 0, 0}, 2, 1, 0};
        tbl[7] = '{0, '{16'd1, 16'd0, 16'd0, 16'd0}, '{1, 0, 0, 0}, 1, 1, 0};
`endif
        tbl[8] = '{0, '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0}, '{0, 0, 0, 0}, 65535, 0, 0};
        tbl[9] = '{0, '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0}, '{1, 1, 0, 0}, 65535, 1, 0};

        rst_n = 1'b0;
        start = 1'b0;
        x = '0; d1 = '0; d2 = '0; d3 = '0;
        xs = 1'b0; d1s = 1'b0; d2s = 1'b0; d3s = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_busy[%0d]", i), longint'(busy[i]), 64'd0);
            chk($sformatf("rst_done[%0d]", i), longint'(done[i]), 64'd0);
            chk($sformatf("rst_y[%0d]", i), longint'(y[i]), 64'd0);
            chk($sformatf("rst_ys[%0d]", i), longint'(ys[i]), 64'd0);
            chk($sformatf("rst_ovf[%0d]", i), longint'(ovf[i]), 64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            run_txn(tbl[t].m, tbl[t].s);
            chk($sformatf("tbl%0d_y", t), longint'(y[tbl[t].inst]), longint'(tbl[t].ey));
            chk($sformatf("tbl%0d_ys", t), longint'(ys[tbl[t].inst]), longint'(tbl[t].eys));
            chk($sformatf("tbl%0d_ovf", t), longint'(ovf[tbl[t].inst]), longint'(tbl[t].eovf));
        end

        // Second start pulse sampled at E2 must be dropped.
        m = '{16'd1234, 16'd4321, 16'd555, 16'd9999};
        s = '{0, 1, 0, 1};
        @(negedge clk);
        drive(m, s);
        start = 1'b1;
        @(posedge clk);
        ndone = 0;
        first = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start = (k == 1);
            if (done[0]) begin
                ndone++;
                if (first < 0) first = k;
                check_all(m, s);
            end
        end
        chk("ignored_start_dones", longint'(ndone), 64'd1);
        chk("ignored_start_pos", longint'(first), 64'd5);

        // start held through the done cycle: re-accepted at E6, so next done at E11.
        m = '{16'd40000, 16'd2, 16'd65535, 16'd7};
        s = '{1, 0, 0, 1};
        @(negedge clk);
        drive(m, s);
        start = 1'b1;
        @(posedge clk);
        ndone  = 0;
        first  = -1;
        second = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            start = (k <= 5);
            if (done[0]) begin
                ndone++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
                check_all(m, s);
            end
        end
        chk("held_start_dones", longint'(ndone), 64'd2);
        chk("held_start_first", longint'(first), 64'd5);
        chk("held_start_second", longint'(second), 64'd11);

        // Reset mid-computation after E2, with a nonzero result already on the outputs.
        m = '{16'd1000, 16'd3000, 16'd0, 16'd0};
        s = '{0, 0, 0, 0};
        run_txn(m, s);
        m = '{16'd500, 16'd700, 16'd0, 16'd0};
        @(negedge clk);
        drive(m, s);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", longint'(busy[0]), 64'd0);
        chk("mid_rst_y", longint'(y[0]), 64'd0);
        chk("mid_rst_done", longint'(done[0]), 64'd0);
        ndone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("mid_rst_no_done", longint'(ndone), 64'd0);
        chk("mid_rst_y_hold", longint'(y[0]), 64'd0);
        m = '{16'd1000, 16'd3000, 16'd0, 16'd0};
        run_txn(m, s);
        chk("post_rst_y", longint'(y[0]), 64'd2000);

        // Random traffic, with extremes mixed in.
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 5))
                    0: m[k] = 16'd0;
                    1: m[k] = 16'hFFFF;
                    default: m[k] = 16'($urandom);
                endcase
                s[k] = 1'($urandom);
            end
            run_txn(m, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
